arb_rr_oht: RTL and testbench

Round-robin arbiter producing a one-hot grant over `WIDTH` requesters, intended to drive the one-hot select of the downstream one-hot data multiplexer directly. It sits in front of that multiplexer and adds a valid/ready handshake toward the consumer. It holds the grant stable while the consumer stalls, and rotates priority after every completed transfer.

---
 rtl/arb_pkg.sv | 35 +++
 rtl/pri_oht.sv | 20 ++
 rtl/arb_rr_oht.sv | 76 +++++++
 tb/tb_arb_rr_oht.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin one-hot arbiter: bit-vector utilities sized
// to a generous maximum width so callers can cast in, then slice out their width.
package arb_pkg;

    localparam int MAXW     = 256;
    localparam int IDX_MAXW = 8;

    typedef logic [MAXW-1:0]     vec_t;
    typedef logic [IDX_MAXW-1:0] bidx_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Isolate the lowest set bit (two's-complement trick).
    function automatic vec_t lsb_oht(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

    function automatic bidx_t oht2bin(input vec_t v);
        bidx_t b;
        b = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (v[i]) b = b | bidx_t'(i);
        end
        return b;
    endfunction

    // All bits at or above the single set bit of p.
    function automatic vec_t therm(input vec_t p);
        return ~(p - vec_t'(1));
    endfunction

endpackage

// File: rtl/pri_oht.sv
// Fixed-priority encoder: lowest-index request wins, output is one-hot or zero.
module pri_oht
    import arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    vec_t full;
    logic unused_hi;

    assign full      = lsb_oht(vec_t'(req));
    assign oht       = full[WIDTH-1:0];
    assign vld       = |req;
    assign unused_hi = ^full[MAXW-1:WIDTH];

endmodule

// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with one-hot grant and valid/ready handshake; the grant is
// frozen while the consumer stalls and priority rotates past each completed transfer.
module arb_rr_oht
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht,
    output logic [IDX_W-1:0] idx,
    output logic             vld,
    input  logic             rdy,
    output logic [WIDTH-1:0] ack
);

    state_t           st, st_nx;
    logic [WIDTH-1:0] ptr, hgr, hgr_nx;
    logic [WIDTH-1:0] mreq, m_oht, u_oht, sel, gnt;
    logic             m_vld, u_vld, xfer;
    vec_t             thm_full;
    bidx_t            ib;
    logic             unused_bits;

    assign thm_full = therm(vec_t'(ptr));
    assign mreq     = req & thm_full[WIDTH-1:0];

    pri_oht #(.WIDTH(WIDTH)) u_pri_m (.req(mreq), .oht(m_oht), .vld(m_vld));
    pri_oht #(.WIDTH(WIDTH)) u_pri_u (.req(req),  .oht(u_oht), .vld(u_vld));

    // Fall back to the unmasked search only when nothing sits at/above the pointer.
    assign sel  = m_vld ? m_oht : u_oht;
    assign gnt  = (st == HOLD) ? hgr : sel;
    assign oht  = rst ? '0 : gnt;
    assign vld  = |oht;
    assign xfer = vld & rdy;
    assign ack  = oht & {WIDTH{xfer}};

    assign ib  = oht2bin(vec_t'(oht));
    assign idx = ib[IDX_W-1:0];

    assign unused_bits = ^{thm_full[MAXW-1:WIDTH], ib[IDX_MAXW-1:IDX_W], u_vld};

    always_comb begin
        st_nx  = st;
        hgr_nx = hgr;
        case (st)
            IDLE: begin
                if (vld && !rdy) begin
                    st_nx  = HOLD;
                    hgr_nx = oht;
                end
            end
            HOLD: begin
                if (rdy) st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            ptr <= WIDTH'(1);
            hgr <= '0;
        end else begin
            st  <= st_nx;
            hgr <= hgr_nx;
            // Next priority goes to the position just above the winner, wrapping.
            if (xfer) ptr <= {oht[WIDTH-2:0], oht[WIDTH-1]};
        end
    end

endmodule

// File: tb/tb_arb_rr_oht.sv
// Bench for arb_rr_oht: directed vector table, then constrained-random traffic
// checked against a behavioural round-robin model through a scoreboard queue.
module tb_arb_rr_oht;

    localparam int W  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b0;
    logic [W-1:0]  req = '0;
    logic [W-1:0]  oht, ack;
    logic [IW-1:0] idx;
    logic          vld;

    always #5 clk = ~clk;

    arb_rr_oht #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .oht(oht),
        .idx(idx), .vld(vld), .rdy(rdy), .ack(ack)
    );

    typedef struct packed {
        logic [W-1:0]  oht;
        logic [IW-1:0] idx;
        logic          vld;
        logic [W-1:0]  ack;
    } exp_t;

    typedef struct {
        logic          rst;
        logic [W-1:0]  req;
        logic          rdy;
        logic [W-1:0]  oht;
        logic [IW-1:0] idx;
        logic [W-1:0]  ack;
        string         name;
    } tv_t;

    exp_t         sb[$];
    tv_t          tbl[$];
    int           total = 0;
    int           bad   = 0;
    int           m_ptr = 0;
    bit           m_hld = 1'b0;
    logic [W-1:0] m_hgr = '0;
    logic [W-1:0] last_ack = '0;
    bit           inv_on = 1'b0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, act, req_v, $time);
        end
    endtask

    function automatic exp_t model_out(input logic r, input logic [W-1:0] q, input logic y);
        exp_t e;
        e = '0;
        if (!r) begin
            if (m_hld) e.oht = m_hgr;
            else begin
                for (int k = 0; k < W; k++) begin
                    int j;
                    j = (m_ptr + k) % W;
                    if (q[j] && e.oht == '0) e.oht[j] = 1'b1;
                end
            end
            for (int j = 0; j < W; j++) if (e.oht[j]) e.idx = IW'(j);
            e.vld = |e.oht;
            e.ack = (e.vld && y) ? e.oht : '0;
        end
        return e;
    endfunction

    task automatic model_adv(input logic r, input logic y, input exp_t e);
        if (r) begin
            m_ptr = 0; m_hld = 1'b0; m_hgr = '0;
        end else if (e.vld && y) begin
            m_ptr = (int'(e.idx) + 1) % W;
            m_hld = 1'b0;
        end else if (e.vld) begin
            m_hld = 1'b1;
            m_hgr = e.oht;
        end
    endtask

    // One clock: push expectation, drive, compare at the falling edge.
    task automatic step(input logic r, input logic [W-1:0] q, input logic y,
                        input string nm, input bit use_tbl, input exp_t te);
        exp_t m, e, got;
        m = model_out(r, q, y);
        sb.push_back(use_tbl ? te : m);
        rst = r; req = q; rdy = y;
        @(negedge clk);
        got = '{oht: oht, idx: idx, vld: vld, ack: ack};
        e = sb.pop_front();
        chk(got === e, nm, 32'(got), 32'(e));
        last_ack = ack;
        model_adv(r, y, m);
        @(posedge clk);
        #1;
    endtask

    // Invariants for the random phase, plus the requester protocol assertion.
    bit            p_stall = 1'b0;
    logic [W-1:0]  p_oht = '0;
    logic [IW-1:0] p_idx = '0;
    int            wcnt[W];

    initial for (int i = 0; i < W; i++) wcnt[i] = 0;

    always @(negedge clk) begin
        int mx;
        if (p_stall && !rst)
            assert ((req & p_oht) != '0) else $error("protocol: held requester dropped req");
        if (inv_on && !rst) begin
            chk($onehot0(oht), "onehot", 32'(oht), 32'(0));
            if (p_stall) chk(oht == p_oht && idx == p_idx, "stable", 32'(oht), 32'(p_oht));
            mx = 0;
            for (int i = 0; i < W; i++) if (wcnt[i] > mx) mx = wcnt[i];
            chk(mx < W, "starve", 32'(mx), 32'(W));
        end
        for (int i = 0; i < W; i++) begin
            if (rst || !req[i] || ack[i]) wcnt[i] = 0;
            else if (vld && rdy) wcnt[i] = wcnt[i] + 1;
        end
        p_stall = vld && !rdy && !rst;
        p_oht   = oht;
        p_idx   = idx;
    end

    initial begin
        logic [W-1:0] q;
        exp_t te;
        // rst, req, rdy, oht, idx, ack
        tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, "rst0"});
        tbl.push_back('{1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 4'b0000, "rst1"});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0010, "alt0"});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b1000, "alt1"});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0010, "alt2"});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b1000, "alt3"});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, "all0"});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0010, "all1"});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0100, "all2"});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 4'b1000, "all3"});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, "wrap"});
        tbl.push_back('{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 4'b0000, "stall1"});
        tbl.push_back('{1'b0, 4'b0111, 1'b0, 4'b0010, 2'd1, 4'b0000, "stall2"});
        tbl.push_back('{1'b0, 4'b0111, 1'b0, 4'b0010, 2'd1, 4'b0000, "stall3"});
        tbl.push_back('{1'b0, 4'b0111, 1'b1, 4'b0010, 2'd1, 4'b0010, "stall_xfer"});
        tbl.push_back('{1'b0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0100, "after_stall"});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0000, "hold_a"});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0000, "hold_b"});
        tbl.push_back('{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 4'b0000, "rst_hold"});
        tbl.push_back('{1'b0, 4'b1100, 1'b1, 4'b0100, 2'd2, 4'b0100, "post_rst"});
        tbl.push_back('{1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b1000, "post_rst2"});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, "idle0"});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "idle1"});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, "idle2"});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "idle3"});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, "idle_ptr"});

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            te = '{oht: tbl[i].oht, idx: tbl[i].idx, vld: |tbl[i].oht, ack: tbl[i].ack};
            step(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].name, 1'b1, te);
        end

        step(1'b1, '0, 1'b0, "rnd_rst", 1'b0, '0);
        inv_on = 1'b1;
        q = '0;
        for (int k = 0; k < 10000; k++) begin
            q = (q & ~last_ack) | (W'($urandom) & W'($urandom));
            step(1'b0, q, ($urandom_range(0, 99) < 60), "rnd", 1'b0, '0);
        end
        inv_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
